data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Parametrised data memory for the CPU load/store path, replacing the fixed 1024x32 block.
- Adds a valid/ready request port, per-byte write enables and a configurable read pipeline.
- Clears itself to zero after reset, then mirrors the low NUM_TAPS words onto a flat tap bus for LEDs/debug.
- Sits between the MEM stage and board I/O.

Parameters:
- ADDR_WIDTH, 10, word address width; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- NUM_TAPS, 4, count of low-address words mirrored on TAP_DATA; legal range 1..2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from read acceptance to RSP_VALID; legal range 1..3.
- CLEAR_ON_RESET, 1, 1 = zero-fill the whole array after reset; 0 = skip the fill.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset; synchronous, active-high.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  request accepted when REQ_VALID && REQ_READY.
- REQ_ADDR  in  ADDR_WIDTH  word address.
- REQ_WE  in  1  1 = write, 0 = read.
- REQ_BE  in  DATA_WIDTH/8  byte-lane write enables; bit i covers bits 8i+7:8i.
- REQ_WDATA  in  DATA_WIDTH  write data.
- RSP_VALID  out  1  read data valid; single-cycle pulse per read.
- RSP_RDATA  out  DATA_WIDTH  read data.
- TAP_DATA  out  NUM_TAPS*DATA_WIDTH  word k occupies bits (k+1)*DATA_WIDTH-1 : k*DATA_WIDTH.
- CLEAR_DONE  out  1  high once the post-reset fill has finished.

Behaviour:
- FSM states: CLEAR, IDLE.
- Reset
  - While RST is high: state <= CLEAR if CLEAR_ON_RESET else IDLE; clear pointer <= 0; all pipeline valids <= 0.
  - Output reset values: RSP_VALID = 0, RSP_RDATA = 0, TAP_DATA = 0, REQ_READY = 0, CLEAR_DONE = 0.
  - Array contents are not reset directly.
- CLEAR
  - Writes 0 to array[ptr] and increments ptr, one word per cycle.
  - After writing word 2**ADDR_WIDTH-1, goes to IDLE. The fill takes exactly 2**ADDR_WIDTH cycles.
  - REQ_READY = 0 throughout.
  - Asserting RST mid-clear restarts the fill at address 0.
- IDLE
  - REQ_READY = 1 combinationally from state; it does not depend on REQ_VALID.
  - CLEAR_DONE = 1 and stays high until the next reset.
  - With CLEAR_ON_RESET=0, IDLE is entered the cycle after RST drops and array contents are undefined.
- Write (accepted, REQ_WE=1)
  - For each i with REQ_BE[i]=1, lane i of array[REQ_ADDR] takes REQ_WDATA lane i at that edge.
  - Lanes with REQ_BE[i]=0 are unchanged. REQ_BE=0 is a legal no-op.
  - No response is produced.
- Read (accepted, REQ_WE=0)
  - The array is read at the acceptance edge. Data travels a READ_LATENCY-stage valid/data pipeline.
  - RSP_VALID is high exactly READ_LATENCY cycles after the acceptance edge.
  - One read per cycle; back-to-back reads give back-to-back responses in order.
  - There is no response backpressure.
  - RSP_RDATA holds its last value when RSP_VALID = 0.
- Read-during-write ordering: a read accepted the cycle after a write to the same address returns the new data.
- Tap shadow
  - TAP word k is a register that is updated in the same edge as any array write to address k (k < NUM_TAPS), with byte-lane masking applied identically.
  - Clear-engine writes update the taps as well, so TAP always equals array[0..NUM_TAPS-1] one cycle after the write edge.
  - Taps are visible on the next cycle; there is no extra latency beyond the register.
- Address range: REQ_ADDR always maps in range because depth is a power of two; no wrap logic is needed.

Test Plan:
- Reset fill: ADDR_WIDTH=4, CLEAR_ON_RESET=1. Pulse RST for 2 cycles, then release.
  - REQ_READY=0 for exactly 16 cycles, then 1; CLEAR_DONE rises on the same cycle.
  - Reading addr 7 returns 0x00000000.
- Byte-lane write: write 0xAABBCCDD to addr 2 with BE=0xF, then 0x11223344 with BE=0b0101, then read addr 2.
  - With READ_LATENCY=1: RSP_RDATA=0xAA22CC44 and RSP_VALID one cycle after acceptance.
  - TAP word 2 = 0xAA22CC44.
- Latency sweep: READ_LATENCY=3. Issue back-to-back reads of addrs 0,1,2 holding 0x10,0x20,0x30.
  - RSP_VALID high on cycles +3,+4,+5 with data 0x10,0x20,0x30.
  - No other RSP_VALID pulses.
- Write-then-read same address: write 0x5 to addr 9 in cycle t, read addr 9 in t+1.
  - Response = 0x5.
- Reset mid-operation: during IDLE, issue a read, then assert RST on the next cycle.
  - No RSP_VALID pulse appears.
  - TAP_DATA = 0 and REQ_READY=0 from the cycle after the reset edge.
  - The fill restarts and takes the full 2**ADDR_WIDTH cycles.
- Tap isolation: NUM_TAPS=4. Write 0xFFFFFFFF to addr 4.
  - All TAP words stay 0.
  - Writing addr 3 changes only bits 127:96 of TAP_DATA.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Data memory for the CPU load/store path: valid/ready request port, byte-lane writes,
// configurable read pipeline, post-reset zero fill and a register mirror of the low words.
module data_memory_ctrl #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_TAPS       = 4,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           REQ_VALID,
    output logic                           REQ_READY,
    input  logic [ADDR_WIDTH-1:0]          REQ_ADDR,
    input  logic                           REQ_WE,
    input  logic [DATA_WIDTH/8-1:0]        REQ_BE,
    input  logic [DATA_WIDTH-1:0]          REQ_WDATA,
    output logic                           RSP_VALID,
    output logic [DATA_WIDTH-1:0]          RSP_RDATA,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] TAP_DATA,
    output logic                           CLEAR_DONE
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int BYTES = DATA_WIDTH / 8;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = {ADDR_WIDTH{1'b1}};

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;

    logic idle;
    logic clr_wr;
    logic accept;
    logic wr_acc;
    logic rd_acc;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [READ_LATENCY-1:0] rsp_vld_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q [READ_LATENCY];

    assign idle       = (state_q == ST_IDLE);
    assign REQ_READY  = idle;
    assign CLEAR_DONE = idle;

    // Requests and fill writes are masked on a reset edge so the array never changes under RST.
    assign clr_wr = (state_q == ST_CLEAR) && !RST && (CLEAR_ON_RESET != 0);
    assign accept = REQ_VALID && idle && !RST;
    assign wr_acc = accept && REQ_WE;
    assign rd_acc = accept && !REQ_WE;

    // Reset always parks in CLEAR; without a fill it drops to IDLE on the first cycle after RST.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == ST_CLEAR) begin
            if (CLEAR_ON_RESET == 0) begin
                state_d = ST_IDLE;
            end else begin
                clr_ptr_d = clr_ptr_q + PTR_ONE;
                if (clr_ptr_q == PTR_LAST) begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (clr_wr) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < BYTES; i++) begin
                if (REQ_BE[i]) begin
                    mem_q[REQ_ADDR][8*i +: 8] <= REQ_WDATA[8*i +: 8];
                end
            end
        end
    end

    // Each data stage loads only behind a valid, so the last stage holds between responses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_vld_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                rsp_data_q[k] <= '0;
            end
        end else begin
            rsp_vld_q[0] <= rd_acc;
            if (rd_acc) begin
                rsp_data_q[0] <= mem_q[REQ_ADDR];
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                rsp_vld_q[k] <= rsp_vld_q[k-1];
                if (rsp_vld_q[k-1]) begin
                    rsp_data_q[k] <= rsp_data_q[k-1];
                end
            end
        end
    end

    assign RSP_VALID = rsp_vld_q[READ_LATENCY-1];
    assign RSP_RDATA = rsp_data_q[READ_LATENCY-1];

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        logic [DATA_WIDTH-1:0] tap_q;

        always_ff @(posedge CLK) begin
            if (RST) begin
                tap_q <= '0;
            end else if (clr_wr && (clr_ptr_q == ADDR_WIDTH'(k))) begin
                tap_q <= '0;
            end else if (wr_acc && (REQ_ADDR == ADDR_WIDTH'(k))) begin
                for (int i = 0; i < BYTES; i++) begin
                    if (REQ_BE[i]) begin
                        tap_q[8*i +: 8] <= REQ_WDATA[8*i +: 8];
                    end
                end
            end
        end

        assign TAP_DATA[k*DATA_WIDTH +: DATA_WIDTH] = tap_q;
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: two instances (read latency 1 and 3) share one request stream
// and are compared every cycle against an array/queue model, plus directed literal checks.
module tb_data_memory_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int NT    = 4;
    localparam int DEPTH = 2 ** AW;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ_VALID;
    logic          REQ_WE;
    logic [AW-1:0] REQ_ADDR;
    logic [3:0]    REQ_BE;
    logic [DW-1:0] REQ_WDATA;

    logic             rdy1, vld1, done1, rdy3, vld3, done3;
    logic [DW-1:0]    rd1, rd3;
    logic [NT*DW-1:0] tap1, tap3;

    always #5 CLK = ~CLK;

    data_memory_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_TAPS(NT), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut1 (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(rdy1), .REQ_ADDR(REQ_ADDR),
        .REQ_WE(REQ_WE), .REQ_BE(REQ_BE), .REQ_WDATA(REQ_WDATA), .RSP_VALID(vld1),
        .RSP_RDATA(rd1), .TAP_DATA(tap1), .CLEAR_DONE(done1));

    data_memory_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_TAPS(NT), .READ_LATENCY(3), .CLEAR_ON_RESET(1)) dut3 (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(rdy3), .REQ_ADDR(REQ_ADDR),
        .REQ_WE(REQ_WE), .REQ_BE(REQ_BE), .REQ_WDATA(REQ_WDATA), .RSP_VALID(vld3),
        .RSP_RDATA(rd3), .TAP_DATA(tap3), .CLEAR_DONE(done3));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: word array, remaining-fill counter, and per-latency response queues.
    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } rsp_t;

    logic [DW-1:0] mmem [DEPTH];
    rsp_t          q1[$];
    rsp_t          q3[$];
    int            cyc      = 0;
    int            clr_left = DEPTH;
    bit            seen_rst = 0;
    logic          exp_v1, exp_v3;
    logic [DW-1:0] hold1, hold3;

    always @(posedge CLK) begin
        rsp_t r;
        cyc++;
        if (RST) begin
            seen_rst = 1;
            clr_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
            q1.delete();
            q3.delete();
            hold1 = '0;
            hold3 = '0;
        end else if (clr_left > 0) begin
            clr_left--;
        end else if (REQ_VALID) begin
            if (REQ_WE) begin
                for (int b = 0; b < 4; b++)
                    if (REQ_BE[b]) mmem[REQ_ADDR][8*b +: 8] = REQ_WDATA[8*b +: 8];
            end else begin
                r.d   = mmem[REQ_ADDR];
                r.due = cyc;
                q1.push_back(r);
                r.due = cyc + 2;
                q3.push_back(r);
            end
        end
        exp_v1 = 1'b0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            exp_v1 = 1'b1;
            hold1  = q1[0].d;
            void'(q1.pop_front());
        end
        exp_v3 = 1'b0;
        if (q3.size() > 0 && q3[0].due == cyc) begin
            exp_v3 = 1'b1;
            hold3  = q3[0].d;
            void'(q3.pop_front());
        end
    end

    always @(negedge CLK) begin
        if (seen_rst) begin
            chk("m_ready1", rdy1, clr_left == 0);
            chk("m_done1",  done1, clr_left == 0);
            chk("m_valid1", vld1, exp_v1);
            chk("m_rdata1", rd1, hold1);
            chk("m_tap1",   tap1, {mmem[3], mmem[2], mmem[1], mmem[0]});
            chk("m_ready3", rdy3, clr_left == 0);
            chk("m_done3",  done3, clr_left == 0);
            chk("m_valid3", vld3, exp_v3);
            chk("m_rdata3", rd3, hold3);
            chk("m_tap3",   tap3, {mmem[3], mmem[2], mmem[1], mmem[0]});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Presents one request for a single edge and returns just after that edge.
    task automatic drive(input logic we, input logic [AW-1:0] addr, input logic [3:0] be, input logic [DW-1:0] wd);
        REQ_VALID = 1'b1;
        REQ_WE    = we;
        REQ_ADDR  = addr;
        REQ_BE    = be;
        REQ_WDATA = wd;
        step(1);
        REQ_VALID = 1'b0;
    endtask

    task automatic wait_fill(input string name);
        int n;
        bit pulse;
        n     = 0;
        pulse = 0;
        while (rdy1 !== 1'b1 && n < 100) begin
            step(1);
            n++;
            if (vld3 === 1'b1) pulse = 1;
        end
        chk(name, n, 16);
        chk({name, "_done"}, done1, 1'b1);
        chk({name, "_nopulse"}, pulse, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST       = 1'b1;
        REQ_VALID = 1'b0;
        REQ_WE    = 1'b0;
        REQ_ADDR  = '0;
        REQ_BE    = '0;
        REQ_WDATA = '0;
        step(2);
        chk("rst_ready", rdy1, 1'b0);
        chk("rst_tap", tap1, 128'h0);
        chk("rst_rsp", {vld1, rd1}, 33'h0);
        RST = 1'b0;
        wait_fill("fill_len");

        drive(1'b0, 4'd7, 4'h0, 32'h0);
        chk("read7_valid", vld1, 1'b1);
        chk("read7_data", rd1, 32'h0);

        drive(1'b1, 4'd2, 4'hF, 32'hAABBCCDD);
        drive(1'b1, 4'd2, 4'b0101, 32'h11223344);
        drive(1'b0, 4'd2, 4'h0, 32'h0);
        chk("be_valid", vld1, 1'b1);
        chk("be_data", rd1, 32'hAA22CC44);
        chk("be_tap2", tap1[95:64], 32'hAA22CC44);

        drive(1'b1, 4'd0, 4'hF, 32'h10);
        drive(1'b1, 4'd1, 4'hF, 32'h20);
        drive(1'b1, 4'd2, 4'hF, 32'h30);
        step(1);
        drive(1'b0, 4'd0, 4'h0, 32'h0);
        drive(1'b0, 4'd1, 4'h0, 32'h0);
        drive(1'b0, 4'd2, 4'h0, 32'h0);
        chk("lat3_r0", {vld3, rd3}, {1'b1, 32'h10});
        step(1);
        chk("lat3_r1", {vld3, rd3}, {1'b1, 32'h20});
        step(1);
        chk("lat3_r2", {vld3, rd3}, {1'b1, 32'h30});
        step(1);
        chk("lat3_after", {vld3, rd3}, {1'b0, 32'h30});

        drive(1'b1, 4'd9, 4'hF, 32'h5);
        drive(1'b0, 4'd9, 4'h0, 32'h0);
        chk("wr_rd_valid", vld1, 1'b1);
        chk("wr_rd_data", rd1, 32'h5);

        drive(1'b0, 4'd9, 4'h0, 32'h0);
        RST = 1'b1;
        step(1);
        chk("midrst_valid3", vld3, 1'b0);
        chk("midrst_tap", tap1, 128'h0);
        chk("midrst_ready", rdy1, 1'b0);
        RST = 1'b0;
        wait_fill("refill_len");

        drive(1'b1, 4'd4, 4'hF, 32'hFFFFFFFF);
        chk("tap_iso4", tap1, 128'h0);
        drive(1'b1, 4'd3, 4'hF, 32'hDEADBEEF);
        chk("tap_iso3", tap1, {32'hDEADBEEF, 96'h0});

        for (int it = 0; it < 600; it++) begin
            RST       = ($urandom_range(0, 199) == 0);
            REQ_VALID = ($urandom_range(0, 3) != 0);
            REQ_WE    = $urandom_range(0, 1);
            REQ_ADDR  = AW'($urandom_range(0, DEPTH - 1));
            REQ_BE    = 4'($urandom_range(0, 15));
            REQ_WDATA = $urandom;
            step(1);
        end
        RST       = 1'b0;
        REQ_VALID = 1'b0;
        step(25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
